// File: rtl/spi_reg_writer_if.sv
// Request-side bus of spi_reg_writer: one frame request in, status and
// captured read byte out. The SPI pins themselves stay plain ports.
interface spi_reg_writer_if;
  logic       start_i;
  logic       wr_i;
  logic [6:0] addr_i;
  logic [7:0] data_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] rd_data_o;

  // Requesting logic (or bench harness)
  modport master (
    output start_i, wr_i, addr_i, data_i,
    input  busy_o, done_o, rd_data_o
  );

  // The SPI controller
  modport slave (
    input  start_i, wr_i, addr_i, data_i,
    output busy_o, done_o, rd_data_o
  );
endinterface

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: sends one 16-bit {R/W, addr[6:0], data[7:0]} frame per
// request, MSB first, SPI mode 0. All outputs are registered.
// Optional feature macro: SPI_REG_WRITER_READBACK_EN -- when defined, cipo_i
// is sampled on the rising edges of the data byte and the byte is presented
// on rd_data_o at frame end; when undefined rd_data_o is tied to 0.
module spi_reg_writer #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_reg_writer_if.slave    bus,
  output logic               ncs_o,
  output logic               sclk_o,
  output logic               copi_o,
  input  logic               cipo_i
);

  // One shared down-counter times setup, each SCLK half-period and hold.
  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                           ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic             phase_reg, phase_next;   // 0 = SCLK low phase, 1 = high
  logic [15:0]      shift_reg, shift_next;
  logic             ncs_reg, ncs_next;
  logic             sclk_reg, sclk_next;
  logic             copi_reg, copi_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // State, counters and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      shift_reg   <= '0;
      ncs_reg     <= 1'b1;
      sclk_reg    <= 1'b0;
      copi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      phase_reg   <= phase_next;
      shift_reg   <= shift_next;
      ncs_reg     <= ncs_next;
      sclk_reg    <= sclk_next;
      copi_reg    <= copi_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Next state and next output values; outputs are computed one cycle
  // ahead so that the pins come straight from flops.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    phase_next   = phase_reg;
    shift_next   = shift_reg;
    ncs_next     = ncs_reg;
    sclk_next    = sclk_reg;
    copi_next    = copi_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        ncs_next  = 1'b1;
        sclk_next = 1'b0;
        copi_next = 1'b0;
        busy_next = 1'b0;
        if (bus.start_i) begin
          state_next = SETUP;
          shift_next = {bus.wr_i, bus.addr_i, bus.data_i};
          cnt_next   = SETUP_LOAD;
          ncs_next   = 1'b0;
          busy_next  = 1'b1;
          copi_next  = bus.wr_i;
        end
      end

      SETUP: begin
        copi_next = shift_reg[15];
        if (cnt_reg == '0) begin
          state_next   = SHIFT;
          cnt_next     = DIV_LOAD;
          phase_next   = 1'b0;
          bit_cnt_next = 4'd15;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      SHIFT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (!phase_reg) begin
          // End of low phase: raise SCLK, data already stable.
          phase_next = 1'b1;
          sclk_next  = 1'b1;
          cnt_next   = DIV_LOAD;
        end else if (bit_cnt_reg == 4'd0) begin
          // Last high phase done; COPI keeps bit 0 through hold.
          state_next = HOLD;
          sclk_next  = 1'b0;
          cnt_next   = HOLD_LOAD;
        end else begin
          // Start of next low phase: the only place COPI advances.
          bit_cnt_next = bit_cnt_reg - 4'd1;
          phase_next   = 1'b0;
          sclk_next    = 1'b0;
          cnt_next     = DIV_LOAD;
          shift_next   = {shift_reg[14:0], 1'b0};
          copi_next    = shift_reg[14];
        end
      end

      HOLD: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          ncs_next   = 1'b1;
          busy_next  = 1'b0;
          copi_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
    endcase
  end

  assign ncs_o      = ncs_reg;
  assign sclk_o     = sclk_reg;
  assign copi_o     = copi_reg;
  assign bus.busy_o = busy_reg;
  assign bus.done_o = done_reg;

`ifdef SPI_REG_WRITER_READBACK_EN
  logic [7:0] rx_reg, rx_next;
  logic [7:0] rd_data_reg, rd_data_next;
  logic       sample_now;
  logic       frame_end;

  // First cycle of a high phase during the data byte, and the HOLD exit.
  assign sample_now = (state_reg == SHIFT) && phase_reg &&
                      (cnt_reg == DIV_LOAD) && (bit_cnt_reg <= 4'd7);
  assign frame_end  = (state_reg == HOLD) && (cnt_reg == '0);

  // Shift CIPO in MSB first; publish the byte together with done.
  always_comb begin
    rx_next      = rx_reg;
    rd_data_next = rd_data_reg;
    if (sample_now) rx_next = {rx_reg[6:0], cipo_i};
    if (frame_end) rd_data_next = rx_reg;
  end

  // Readback capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_reg      <= '0;
      rd_data_reg <= '0;
    end else begin
      rx_reg      <= rx_next;
      rd_data_reg <= rd_data_next;
    end
  end

  assign bus.rd_data_o = rd_data_reg;
`else
  logic unused_cipo;
  assign unused_cipo   = cipo_i;
  assign bus.rd_data_o = 8'h00;
`endif

endmodule
